stream_mux_nx1: RTL

// - Parametrised N-to-1 stream multiplexer with valid/ready handshakes on every input and on the output.
// - Selection is done by a round-robin arbiter, not an external select line.
// - One registered output stage, so the block runs at full throughput with a 1-cycle latency.
// - Sits between CH producer channels and a single shared downstream consumer.
//

---
 rtl/stream_mux_nx1.sv | 124 ++++++++++++
 1 files changed

// File: rtl/stream_mux_nx1.sv
// N-to-1 valid/ready stream mux: round-robin arbitration feeding one registered output stage.
// Defining STREAM_MUX_PKT_LOCK_EN holds the grant on one channel until its in_last beat (no packet interleave).
module stream_mux_nx1 #(
    parameter int W    = 8,
    parameter int CH   = 4,
    parameter int SELW = $clog2(CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH*W-1:0] in_data,
    input  logic [CH-1:0]   in_valid,
    input  logic [CH-1:0]   in_last,
    output logic [CH-1:0]   in_ready,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    output logic            out_last,
    output logic [SELW-1:0] out_sel,
    input  logic            out_ready
);

    localparam int IW = SELW + 1;

    logic [W-1:0]    ch_data [CH];
    logic [SELW-1:0] ptr_q;
    logic [SELW-1:0] ptr_d;
    logic [SELW-1:0] rr_grant;
    logic            rr_vld;
    logic [SELW-1:0] grant;
    logic            grant_vld;
    logic            load_en;
    logic            xfer;
    logic [W-1:0]    out_data_q;
    logic            out_valid_q;
    logic            out_last_q;
    logic [SELW-1:0] out_sel_q;

    assign load_en = !rst && (!out_valid_q || out_ready);
    assign xfer    = load_en && grant_vld;

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            assign ch_data[gi]  = in_data[gi*W +: W];
            assign in_ready[gi] = load_en && grant_vld && in_valid[gi] && (grant == SELW'(gi));
        end
    endgenerate

    // Scan from the farthest offset down so the nearest valid channel after ptr wins.
    always_comb begin
        logic [IW-1:0] idx;
        idx      = '0;
        rr_grant = '0;
        rr_vld   = 1'b0;
        for (int k = CH - 1; k >= 0; k--) begin
            idx = {1'b0, ptr_q} + IW'(k);
            if (idx >= IW'(CH)) begin
                idx = idx - IW'(CH);
            end
            if (in_valid[idx[SELW-1:0]]) begin
                rr_grant = idx[SELW-1:0];
                rr_vld   = 1'b1;
            end
        end
    end

`ifdef STREAM_MUX_PKT_LOCK_EN
    logic            lock_q;
    logic [SELW-1:0] lock_ch_q;

    always_comb begin
        if (lock_q) begin
            grant     = lock_ch_q;
            grant_vld = in_valid[lock_ch_q];
        end else begin
            grant     = rr_grant;
            grant_vld = rr_vld;
        end
    end
`else
    assign grant     = rr_grant;
    assign grant_vld = rr_vld;
`endif

    // Explicit wrap keeps the pointer legal for non-power-of-two CH.
    assign ptr_d = (grant == SELW'(CH - 1)) ? '0 : grant + SELW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
            lock_q      <= 1'b0;
            lock_ch_q   <= '0;
`endif
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= ch_data[grant];
            out_last_q  <= in_last[grant];
            out_sel_q   <= grant;
`ifdef STREAM_MUX_PKT_LOCK_EN
            if (in_last[grant]) begin
                lock_q <= 1'b0;
                ptr_q  <= ptr_d;
            end else begin
                lock_q    <= 1'b1;
                lock_ch_q <= grant;
            end
`else
            ptr_q <= ptr_d;
`endif
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_sel   = out_sel_q;

endmodule
